// File: rtl/network_scheduler.sv
// network_scheduler: round-robin arbiter that time-shares one network_control instance among NUM_REQ requesters.
// Latency: done pulses 3 cycles + network compute time after the IDLE arbitration cycle; one IDLE cycle separates jobs.
// Backpressure: req is a level held by the requester until its done/err pulse; req is only sampled in IDLE.
//
// Ports:
//   clk, n_rst          clock (rising edge) and asynchronous active-low reset
//   req / req_data      per-requester request level and operands (requester r at slice r)
//   grant / done / err  one-hot owner of the job in flight, completion pulse, timeout-abort pulse
//   result              result of the last completed job, held between jobs
//   net_ctrl / net_din  network control_in (bit0 = start/clear) and operand bus
//   net_status/net_dout network control_out (bit0 = finish) and result bus
//
// Optional feature: define NET_SCHED_TIMEOUT_EN to abort a job with err after TIMEOUT_CYCLES RUN cycles
// without finish. Without it RUN waits indefinitely and err is constant 0.

module network_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int INPUT_SIZE     = 2,
    parameter int OUTPUT_SIZE    = 1,
    parameter int TIMEOUT_CYCLES = 300
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*INPUT_SIZE*32-1:0] req_data,
    output logic [NUM_REQ-1:0]              grant,
    output logic [NUM_REQ-1:0]              done,
    output logic [NUM_REQ-1:0]              err,
    output logic [OUTPUT_SIZE*32-1:0]       result,
    output logic [7:0]                      net_ctrl,
    input  logic [7:0]                      net_status,
    output logic [INPUT_SIZE*32-1:0]        net_din,
    input  logic [OUTPUT_SIZE*32-1:0]       net_dout
);
    localparam int IN_W  = INPUT_SIZE * 32;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, CAPTURE} state_t;

    state_t           state;
    logic [IDX_W-1:0] last_winner;
    logic [IDX_W-1:0] winner;
    logic             start_q;
    logic             finish;
    logic             unused_status;

    // Round-robin search result
    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    int               cand;

    assign finish        = net_status[0];
    assign unused_status = ^net_status[7:1];
    // Only bit0 is ever driven; it doubles as the network clear, so it is a registered single-cycle pulse.
    assign net_ctrl      = {7'b0, start_q};

    // Scan from the requester after the last winner, wrapping around; the first active req wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_winner) + i) % NUM_REQ;
            if (!win_vld && req[IDX_W'(cand)]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

`ifdef NET_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]   run_cnt;
    logic [NUM_REQ-1:0] err_q;
    logic               timeout;

    // run_cnt is 0 in the first RUN cycle, so the abort lands exactly TIMEOUT_CYCLES cycles after RUN entry.
    assign timeout = (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign err            = '0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            grant       <= '0;
            done        <= '0;
            start_q     <= 1'b0;
            net_din     <= '0;
            result      <= '0;
            winner      <= '0;
            // Pointing at the highest index gives requester 0 first priority after reset.
            last_winner <= IDX_W'(NUM_REQ - 1);
`ifdef NET_SCHED_TIMEOUT_EN
            err_q       <= '0;
            run_cnt     <= '0;
`endif
        end else begin
            done    <= '0;
            start_q <= 1'b0;
`ifdef NET_SCHED_TIMEOUT_EN
            err_q   <= '0;
`endif
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        winner  <= win_idx;
                        grant   <= ONE_HOT0 << win_idx;
                        net_din <= req_data[int'(win_idx)*IN_W +: IN_W];
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    // net_din has been stable for a full cycle; raise start for the next cycle only.
                    start_q <= 1'b1;
                    state   <= START;
                end
                START: begin
`ifdef NET_SCHED_TIMEOUT_EN
                    run_cnt <= '0;
`endif
                    state   <= RUN;
                end
                RUN: begin
                    if (finish) begin
                        // net_dout is only guaranteed while finish is high, so capture it on this edge.
                        result <= net_dout;
                        done   <= grant;
                        state  <= CAPTURE;
                    end
`ifdef NET_SCHED_TIMEOUT_EN
                    else if (timeout) begin
                        err_q       <= grant;
                        grant       <= '0;
                        last_winner <= winner;
                        state       <= IDLE;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
`endif
                end
                CAPTURE: begin
                    // done is visible this cycle with grant still set; release ownership on exit.
                    grant       <= '0;
                    last_winner <= winner;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/network_scheduler.md
NETWORK_SCHEDULER -- requirements
Module: network_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one network_control instance (2..8).
REQ-002 Parameter INPUT_SIZE, default 2: operands per job, each a 32-bit signed int.
REQ-003 Parameter OUTPUT_SIZE, default 1: results per job, each a 32-bit signed int.
REQ-004 Parameter TIMEOUT_CYCLES, default 300: watchdog limit, used only when the timeout feature is compiled in.
REQ-005 Port clk  in  1: single clock; all logic is rising-edge.
REQ-006 Port n_rst  in  1: reset, asynchronous and active-low.
REQ-007 Port req  in  NUM_REQ: per-requester job request level.
REQ-008 Port req_data  in  NUM_REQ*INPUT_SIZE*32: operands, requester r at slice r.
REQ-009 Port grant  out  NUM_REQ: one-hot, marks the requester whose job is in flight.
REQ-010 Port done  out  NUM_REQ: one-cycle pulse to the owning requester when its result is valid.
REQ-011 Port err  out  NUM_REQ: one-cycle pulse to the owning requester on timeout abort.
REQ-012 Port result  out  OUTPUT_SIZE*32: result of the last completed job.
REQ-013 Port net_ctrl  out  8: drives network control_in; bit0 = start/clear, bits 7:1 = 0.
REQ-014 Port net_status  in  8: from network control_out; bit0 = finish, bits 7:6 = network state.
REQ-015 Port net_din  out  INPUT_SIZE*32: operands to the network data_in.
REQ-016 Port net_dout  in  OUTPUT_SIZE*32: network data_out.

Function
REQ-017 FSM states: IDLE, LOAD, START, RUN, CAPTURE.
REQ-018 IDLE: when any req is high, select the winner round-robin starting at index (last_winner+1) mod NUM_REQ, latch its req_data into net_din, set grant, go to LOAD; stay in IDLE otherwise.
REQ-019 LOAD: hold net_ctrl = 0 for one cycle so that net_din is stable before start; go to START.
REQ-020 START: drive net_ctrl[0] = 1 for exactly one cycle (bit0 also clears the network, so it must never be held); go to RUN.
REQ-021 RUN: net_ctrl = 0; on net_status[0] = 1, go to CAPTURE.
REQ-022 CAPTURE: register net_dout into result, pulse done[winner] for one cycle, clear grant, update last_winner, and go to IDLE.
REQ-023 Latency from the grant cycle to the done pulse: 3 cycles plus the network compute time (the network holds finish for one cycle after 256 compute cycles).
REQ-024 The scheduler ignores req changes while not in IDLE; the granted requester dropping req mid-job does not abort the job.
REQ-025 net_din and result hold their values between jobs; result changes only in CAPTURE.
REQ-026 When several req bits rise in the same cycle, the tie resolves by the round-robin order; no requester waits more than NUM_REQ-1 jobs.
REQ-027 A req still high in the cycle that done pulses is eligible again in the next IDLE cycle, subject to round-robin priority.
REQ-028 A finish seen outside RUN is ignored.

Reset
REQ-029 Assertion of n_rst immediately sets state = IDLE, grant = 0, done = 0, err = 0, net_ctrl = 0, net_din = 0, result = 0, and last_winner = NUM_REQ-1, so that requester 0 has first priority.
REQ-030 Reset mid-job discards the job with no done or err pulse; the first job after deassertion begins normally.

Configuration
REQ-031 Macro NET_SCHED_TIMEOUT_EN defined: a cycle counter clears on entry to RUN and increments each RUN cycle; on reaching TIMEOUT_CYCLES without finish, pulse err[winner], leave result unchanged, clear grant, update last_winner, and go to IDLE.
REQ-032 Macro NET_SCHED_TIMEOUT_EN undefined: no counter; RUN waits indefinitely, and err is tied to 0.

Verification
REQ-033 Single req[1] with operands (10, -3); network model finishes 256 cycles after start -> grant = 0010 for the whole job, a single start pulse, done[1] pulse, and result = the model output.
REQ-034 req = 1111 held from reset -> grant order 0, 1, 2, 3, 0, each job separated by exactly one IDLE cycle.
REQ-035 req[2] dropped during RUN -> job completes and done[2] still pulses.
REQ-036 NET_SCHED_TIMEOUT_EN with TIMEOUT_CYCLES = 300 and a model that never asserts finish -> err[0] pulses 300 cycles after entry to RUN, result unchanged, next requester granted.
REQ-037 n_rst low during RUN for req[3] -> all outputs 0 asynchronously, no done or err pulse; after release, req = 1000 is granted with grant = 1000.
REQ-038 Finish pulse injected in IDLE -> no state change and no done pulse.
